mgmt_gpio_retimer: RTL and testbench
====================================

# mgmt_gpio_retimer

Synchronous retiming stage between the housekeeping GPIO registers and the management-GPIO pad buffer. On the input side it synchronizes the buffered pad inputs, debounces each pin with a programmable filter, and latches selected edges into sticky status bits that drive one interrupt. On the output side it registers the output-value and output-enable words under a write strobe, so the pad buffer always sees glitch-free, clock-aligned values that reset to a safe state.

## Interface
Parameters:
- NPINS, default 19 (`MPRJ_IO_PADS_1`): number of management GPIO pins.
- NOEB, default 3: number of output-enable controls driven toward the pad buffer.
- DBW, default 4: debounce counter width.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- mgmt_gpio_in_buf  in  NPINS  buffered pad inputs; asynchronous to wb_clk_i.
- db_len  in  DBW  debounce length N; quasi-static.
- edge_sel  in  NPINS  per pin: 1 latches rising edges, 0 latches falling edges.
- irq_mask  in  NPINS  per pin: 1 enables the pin's status bit onto irq.
- irq_clear  in  NPINS  per pin: 1-cycle write-one-to-clear of status.
- gpio_in_o  out  NPINS  debounced input value.
- edge_status  out  NPINS  sticky edge status bits.
- irq  out  1  registered OR of (edge_status & irq_mask).
- out_wr  in  1  load strobe for the output registers.
- gpio_out_i  in  NPINS  output value from housekeeping.
- gpio_oeb_i  in  NOEB  output-enable bars from housekeeping.
- mgmt_gpio_out  out  NPINS  registered output value toward the pad buffer.
- mgmt_gpio_oeb  out  NOEB  registered output-enable bars toward the pad buffer.

## Operation
- Synchronizer: two flops per pin, s1 <= mgmt_gpio_in_buf and s2 <= s1. No logic between s1 and s2.
- Debounce: each pin i keeps a stable value d[i] (driven onto gpio_in_o[i]) and a counter c[i] of width DBW.
  - If s2[i] == d[i]: c[i] <= 0.
  - If s2[i] != d[i] and c[i] == db_len: d[i] <= s2[i] and c[i] <= 0.
  - If s2[i] != d[i] otherwise: c[i] <= c[i] + 1.
- Debounce consequences:
  - db_len = 0 means d follows s2 with a 1-cycle lag; the filter is bypassed.
  - The counter never exceeds db_len, so it cannot wrap.
  - A change in db_len takes effect on the next compare. If db_len is lowered below a running count, the counter keeps incrementing through wrap-around; this is legal but the team does not use it.
  - A glitch that holds s2 for N or fewer cycles is rejected and the counter returns to 0.
- Edge detection: ev[i] is asserted in the cycle d[i] updates, in the direction selected by edge_sel[i].
  - edge_status[i] <= ev[i] | (edge_status[i] & ~irq_clear[i]).
  - If set and clear coincide, set wins.
- Interrupt: irq <= |(edge_status & irq_mask). This register is updated every cycle.
- Output path:
  - When out_wr = 1: mgmt_gpio_out <= gpio_out_i and mgmt_gpio_oeb <= gpio_oeb_i.
  - Otherwise both hold their values.
- Reset, synchronous with priority over all other logic:
  - s1, s2, d, c, edge_status, irq and mgmt_gpio_out are cleared to 0.
  - mgmt_gpio_oeb is set to all-ones, so every pad is an input.
  - After reset release, d = 0. Any pin held at 1 produces a debounced rise N+3 cycles later. If edge_sel = 1 for that pin, this sets its status bit.
  - Reset asserted mid-debounce discards the count.

## Timing
- Input latency, pad edge to gpio_in_o: 3 + N rising edges, counting the capturing edge as 1.
  - s1 is valid at edge 1 and s2 at edge 2.
  - d updates at edge 3 + N, provided s2 stays stable.
- edge_status is set on the same edge that d updates.
- irq is valid one edge after edge_status; clearing deasserts it one edge after the clear.
- The output path has 1-cycle latency: values are visible on the edge where out_wr is sampled high.
- There is no back-pressure and no handshake. out_wr and irq_clear are single-cycle level samples.

## Test plan
- Reset: apply wb_rst_i for 2 cycles with random inputs -> mgmt_gpio_oeb = 3'b111 and mgmt_gpio_out, gpio_in_o, edge_status and irq all = 0.
- Debounce pass: db_len = 4, edge_sel[5] = 1, irq_mask[5] = 1, drive pin 5 0->1 and hold -> gpio_in_o[5] rises at edge 7, edge_status[5] at edge 7, irq at edge 8.
- Glitch reject: db_len = 4, drive a 4-cycle high pulse on pin 2 -> gpio_in_o[2] stays 0 and no status is set. A 5-cycle pulse -> gpio_in_o[2] pulses high.
- Edge polarity and clear: edge_sel[0] = 0, pin 0 goes 1->0 with db_len = 0 -> status[0] is set 3 cycles after the change. Pulse irq_clear[0] in the same cycle as a new falling edge -> status stays 1. A clear without an edge -> status returns to 0 and irq drops 1 cycle later.
- Output registers: gpio_out_i = 19'h5A5A5, gpio_oeb_i = 3'b010, out_wr pulse -> outputs take those values on that edge. Change the inputs with out_wr = 0 -> outputs hold.
- Reset mid-count: db_len = 15, assert reset 8 cycles into a transition, release, then hold the pin high -> gpio_in_o rises exactly 18 edges after release.

Source files
------------

// File: rtl/mgmt_gpio_retimer.sv
// Retiming stage between housekeeping GPIO registers and the mgmt pad buffer.
// Inputs: sync, debounce, sticky edge status and irq. Outputs: strobed registers.
module mgmt_gpio_retimer #(
  parameter int NPINS = 19,
  parameter int NOEB  = 3,
  parameter int DBW   = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NPINS-1:0] mgmt_gpio_in_buf,
  input  logic [DBW-1:0]   db_len,
  input  logic [NPINS-1:0] edge_sel,
  input  logic [NPINS-1:0] irq_mask,
  input  logic [NPINS-1:0] irq_clear,
  output logic [NPINS-1:0] gpio_in_o,
  output logic [NPINS-1:0] edge_status,
  output logic             irq,
  input  logic             out_wr,
  input  logic [NPINS-1:0] gpio_out_i,
  input  logic [NOEB-1:0]  gpio_oeb_i,
  output logic [NPINS-1:0] mgmt_gpio_out,
  output logic [NOEB-1:0]  mgmt_gpio_oeb
);

  logic [NPINS-1:0] s1;
  logic [NPINS-1:0] s2;
  logic [NPINS-1:0] d;
  logic [NPINS-1:0] d_nxt;
  logic [NPINS-1:0] ev;
  logic [DBW-1:0]   c     [NPINS];
  logic [DBW-1:0]   c_nxt [NPINS];

  always_comb begin
    d_nxt = d;
    ev    = '0;
    for (int i = 0; i < NPINS; i++) begin
      c_nxt[i] = c[i];
      if (s2[i] == d[i]) begin
        c_nxt[i] = '0;
      end else if (c[i] == db_len) begin
        d_nxt[i] = s2[i];
        c_nxt[i] = '0;
        // edge_sel=1 selects rise (new value 1), 0 selects fall
        ev[i]    = (s2[i] == edge_sel[i]);
      end else begin
        c_nxt[i] = c[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1            <= '0;
      s2            <= '0;
      d             <= '0;
      edge_status   <= '0;
      irq           <= 1'b0;
      mgmt_gpio_out <= '0;
      mgmt_gpio_oeb <= '1;
      for (int i = 0; i < NPINS; i++) c[i] <= '0;
    end else begin
      s1          <= mgmt_gpio_in_buf;
      s2          <= s1;
      d           <= d_nxt;
      edge_status <= ev | (edge_status & ~irq_clear);
      irq         <= |(edge_status & irq_mask);
      for (int i = 0; i < NPINS; i++) c[i] <= c_nxt[i];
      if (out_wr) begin
        mgmt_gpio_out <= gpio_out_i;
        mgmt_gpio_oeb <= gpio_oeb_i;
      end
    end
  end

  assign gpio_in_o = d;

endmodule

// File: tb/tb_mgmt_gpio_retimer.sv
// Directed bench for mgmt_gpio_retimer.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_mgmt_gpio_retimer;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] pad;
  logic [3:0]  db_len;
  logic [18:0] edge_sel;
  logic [18:0] irq_mask;
  logic [18:0] irq_clear;
  logic [18:0] gpio_in_o;
  logic [18:0] edge_status;
  logic        irq;
  logic        out_wr;
  logic [18:0] gpio_out_i;
  logic [2:0]  gpio_oeb_i;
  logic [18:0] mgmt_gpio_out;
  logic [2:0]  mgmt_gpio_oeb;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mgmt_gpio_retimer dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .mgmt_gpio_in_buf(pad),
    .db_len          (db_len),
    .edge_sel        (edge_sel),
    .irq_mask        (irq_mask),
    .irq_clear       (irq_clear),
    .gpio_in_o       (gpio_in_o),
    .edge_status     (edge_status),
    .irq             (irq),
    .out_wr          (out_wr),
    .gpio_out_i      (gpio_out_i),
    .gpio_oeb_i      (gpio_oeb_i),
    .mgmt_gpio_out   (mgmt_gpio_out),
    .mgmt_gpio_oeb   (mgmt_gpio_oeb)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_all();
    irq_clear = '1;
    tick(1);
    irq_clear = '0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    pad        = 19'($urandom);
    edge_sel   = 19'($urandom);
    irq_mask   = 19'($urandom);
    irq_clear  = 19'($urandom);
    out_wr     = 1'b1;
    gpio_out_i = 19'($urandom);
    gpio_oeb_i = 3'($urandom);
    db_len     = 4'($urandom);
    tick(2);
    tests++;
    if (mgmt_gpio_oeb !== 3'b111) begin
      failed++;
      $display("FAIL reset_oeb got %b exp 111", mgmt_gpio_oeb);
    end
    tests++;
    if ({mgmt_gpio_out, gpio_in_o, edge_status, irq} !== '0) begin
      failed++;
      $display("FAIL reset_zero out=%h in=%h st=%h irq=%b exp all 0",
               mgmt_gpio_out, gpio_in_o, edge_status, irq);
    end
    pad       = '0;
    edge_sel  = '0;
    irq_mask  = '0;
    irq_clear = '0;
    out_wr    = 1'b0;
    db_len    = 4'd4;
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_debounce_pass();
    db_len      = 4'd4;
    edge_sel[5] = 1'b1;
    irq_mask[5] = 1'b1;
    pad[5]      = 1'b1;
    tick(6);
    tests++;
    if (gpio_in_o[5] !== 1'b0) begin
      failed++;
      $display("FAIL db_early got %b exp 0", gpio_in_o[5]);
    end
    tick(1);
    tests++;
    if (gpio_in_o[5] !== 1'b1 || edge_status[5] !== 1'b1 || irq !== 1'b0) begin
      failed++;
      $display("FAIL db_edge7 in=%b st=%b irq=%b exp 1 1 0",
               gpio_in_o[5], edge_status[5], irq);
    end
    tick(1);
    tests++;
    if (irq !== 1'b1) begin
      failed++;
      $display("FAIL db_irq8 got %b exp 1", irq);
    end
    irq_mask = '0;
    clear_all();
    tick(1);
  endtask

  task automatic test_glitch();
    logic seen;
    db_len      = 4'd4;
    edge_sel[2] = 1'b1;
    pad[2]      = 1'b1;
    tick(4);
    pad[2] = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (gpio_in_o[2] === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0 || edge_status[2] !== 1'b0) begin
      failed++;
      $display("FAIL glitch4 seen=%b st=%b exp 0 0", seen, edge_status[2]);
    end
    pad[2] = 1'b1;
    tick(5);
    pad[2] = 1'b0;
    tick(2);
    tests++;
    if (gpio_in_o[2] !== 1'b1 || edge_status[2] !== 1'b1) begin
      failed++;
      $display("FAIL glitch5 in=%b st=%b exp 1 1", gpio_in_o[2], edge_status[2]);
    end
    tick(7);
    tests++;
    if (gpio_in_o[2] !== 1'b0) begin
      failed++;
      $display("FAIL glitch5_fall got %b exp 0", gpio_in_o[2]);
    end
    clear_all();
  endtask

  task automatic test_polarity_clear();
    db_len      = 4'd0;
    edge_sel[0] = 1'b0;
    pad[0]      = 1'b1;
    tick(3);
    tests++;
    if (gpio_in_o[0] !== 1'b1 || edge_status[0] !== 1'b0) begin
      failed++;
      $display("FAIL pol_rise in=%b st=%b exp 1 0", gpio_in_o[0], edge_status[0]);
    end
    tick(2);
    pad[0] = 1'b0;
    tick(2);
    tests++;
    if (edge_status[0] !== 1'b0) begin
      failed++;
      $display("FAIL pol_early got %b exp 0", edge_status[0]);
    end
    tick(1);
    tests++;
    if (edge_status[0] !== 1'b1 || gpio_in_o[0] !== 1'b0) begin
      failed++;
      $display("FAIL pol_fall st=%b in=%b exp 1 0", edge_status[0], gpio_in_o[0]);
    end
    irq_mask    = '0;
    irq_mask[0] = 1'b1;
    tick(1);
    tests++;
    if (irq !== 1'b1) begin
      failed++;
      $display("FAIL pol_irq got %b exp 1", irq);
    end
    pad[0] = 1'b1;
    tick(4);
    pad[0] = 1'b0;
    tick(2);
    irq_clear[0] = 1'b1;
    tick(1);
    irq_clear[0] = 1'b0;
    tests++;
    if (edge_status[0] !== 1'b1 || gpio_in_o[0] !== 1'b0) begin
      failed++;
      $display("FAIL set_wins st=%b in=%b exp 1 0", edge_status[0], gpio_in_o[0]);
    end
    tick(1);
    irq_clear[0] = 1'b1;
    tick(1);
    irq_clear[0] = 1'b0;
    tests++;
    if (edge_status[0] !== 1'b0 || irq !== 1'b1) begin
      failed++;
      $display("FAIL clr st=%b irq=%b exp 0 1", edge_status[0], irq);
    end
    tick(1);
    tests++;
    if (irq !== 1'b0) begin
      failed++;
      $display("FAIL clr_irq got %b exp 0", irq);
    end
  endtask

  task automatic test_output_regs();
    gpio_out_i = 19'h5A5A5;
    gpio_oeb_i = 3'b010;
    out_wr     = 1'b1;
    tick(1);
    out_wr = 1'b0;
    tests++;
    if (mgmt_gpio_out !== 19'h5A5A5 || mgmt_gpio_oeb !== 3'b010) begin
      failed++;
      $display("FAIL out_load out=%h oeb=%b exp 5a5a5 010", mgmt_gpio_out, mgmt_gpio_oeb);
    end
    gpio_out_i = 19'h2A5A1;
    gpio_oeb_i = 3'b101;
    tick(2);
    tests++;
    if (mgmt_gpio_out !== 19'h5A5A5 || mgmt_gpio_oeb !== 3'b010) begin
      failed++;
      $display("FAIL out_hold out=%h oeb=%b exp 5a5a5 010", mgmt_gpio_out, mgmt_gpio_oeb);
    end
  endtask

  task automatic test_reset_mid_count();
    db_len = 4'd15;
    pad[7] = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(2);
    tests++;
    if (mgmt_gpio_oeb !== 3'b111 || gpio_in_o !== '0) begin
      failed++;
      $display("FAIL mid_rst oeb=%b in=%h exp 111 0", mgmt_gpio_oeb, gpio_in_o);
    end
    rst = 1'b0;
    tick(17);
    tests++;
    if (gpio_in_o[7] !== 1'b0) begin
      failed++;
      $display("FAIL mid_early got %b exp 0", gpio_in_o[7]);
    end
    tick(1);
    tests++;
    if (gpio_in_o[7] !== 1'b1) begin
      failed++;
      $display("FAIL mid_edge18 got %b exp 1", gpio_in_o[7]);
    end
  endtask

  initial begin
    test_reset();
    test_debounce_pass();
    test_glitch();
    test_polarity_clear();
    test_output_regs();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
